dm_stage: RTL and testbench
===========================

# dm_stage

Memory-stage data-memory block of the five-stage MIPS pipeline. Takes the M-stage address, store data and access size, and drives the byte-enabled synchronous data memory or the peripheral bridge. Registers the raw read word plus the size/sign/address/hit fields into the M/W boundary for the W-stage load extender. Detects misaligned accesses for CP0.

## Interface
Parameters:
- DM_WORDS, 4096: memory depth in 32-bit words (16 KiB).
- DM_BASE, 32'h0000_0000: byte base address of the data memory.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush_M  in  1  kill the M-stage instruction (exception/interrupt entry); no write, W gets a bubble.
- MemWrite_M  in  1  store in M.
- MemRead_M  in  1  load in M.
- sizesel_M  in  2  access size: 11 word, 01 half, 10 byte; 00 is illegal and is treated as no access.
- signedsel_M  in  1  load sign-extension request, passed through to W.
- ALUout_M  in  32  effective byte address.
- WD_M  in  32  store data (rt, forwarded).
- DM_Wtemp  out  32  raw memory word for the W-stage extender.
- HitDMW  out  1  W instruction addressed data memory.
- ALUout_W  out  32  registered address.
- loadselW  out  2  registered sizesel_M.
- signedselW  out  1  registered signedsel_M.
- PrAddr  out  32  bridge address (equals ALUout_M).
- PrWD  out  32  bridge write data (equals WD_M, not lane-replicated).
- PrWe  out  1  bridge write strobe.
- AdEL_M  out  1  misaligned load.
- AdES_M  out  1  misaligned store.

## Operation
- Hit: HitDM_M = ALUout_M in [DM_BASE, DM_BASE+4*DM_WORDS-1]. Word index = (ALUout_M-DM_BASE)[log2(4*DM_WORDS)-1:2].
- Byte enables:
  - word: 1111.
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - byte: 0001 << addr[1:0].
- Write lanes: word = WD_M; half = {2{WD_M[15:0]}}; byte = {4{WD_M[7:0]}}. Only enabled lanes are updated.
- DM write at posedge when all hold: MemWrite_M, HitDM_M, no misalign, no flush_M, reset high.
- PrWe = MemWrite_M & !HitDM_M & !misalign & !flush_M (combinational).
- Read: word at the M index is captured into DM_Wtemp at posedge. The read is full-word regardless of size. It captures every cycle and is 0 for a non-hit or non-read access.
- M/W register: ALUout_W, loadselW, signedselW and HitDMW (= HitDM_M & MemRead_M) load every cycle. There is no W stall.
  - flush_M or misalign loads a bubble: all four fields 0 and DM_Wtemp 0.
- Misalign: word needs addr[1:0]=00; half needs addr[0]=0; byte is never misaligned.
  - AdEL_M = MemRead_M & misalign & !flush_M.
  - AdES_M = MemWrite_M & misalign & !flush_M.
- Memory contents are not reset. Software writes before it reads.

## Timing
- Reset (async, low): DM_Wtemp, ALUout_W, loadselW, signedselW, HitDMW = 0. Memory writes are inhibited while reset is low, including a store in flight.
- Load latency: M cycle t produces W outputs after the posedge ending t.
- Store then load, back-to-back, same word: the load at t+1 reads the stored data. The synchronous write completes at the edge ending t.
- PrAddr, PrWD, PrWe, AdEL_M and AdES_M are combinational from M inputs within the same cycle.
- MemRead_M and MemWrite_M are never both 1. If they are, the store wins and HitDMW = 0.

## Configuration
- DM_ALIGN_CHECK_EN defined: misalign detection as above.
- DM_ALIGN_CHECK_EN undefined: AdEL_M and AdES_M are tied 0; misalign is always 0; low address bits are ignored for indexing. Enables still follow addr[1:0], so a misaligned half store at addr[1:0]=01 writes lanes 0011.

## Structure
- Shared package mips_pkg holds the size encodings (SZ_WORD=2'b11, SZ_HALF=2'b01, SZ_BYTE=2'b10), DM_BASE, and the exception codes AdEL=4, AdES=5 used by CP0.
- One sub-module, dm_ram: DM_WORDS x 32 array with 4-bit byte write enable and registered read.
- Decode, lane replication and the M/W register live in dm_stage.

## Test plan
- sw 0x12345678 at 0x10, then lw 0x10 → next cycle DM_Wtemp=0x12345678, loadselW=11, HitDMW=1.
- sh 0xBEEF at 0x12, then sb 0xAA at 0x11, then lw 0x10 → DM_Wtemp=0xBEEFAA78.
- sw at 0x13 (macro on) → AdES_M=1 the same cycle, word 0x10 unchanged, W bubble. With the macro off: AdES_M=0 and word 0x10 is overwritten.
- sw 0xCAFE0000 at 0x7F10 (outside DM) → PrWe=1, PrAddr=0x7F10, PrWD=0xCAFE0000, no DM write, next-cycle HitDMW=0.
- store with flush_M=1 → PrWe=0, memory unchanged, W outputs all 0.
- reset pulled low mid-store, before the edge → store not committed, all W outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: access-size encodings, data-memory base,
// CP0 address-error codes and byte-lane helpers used by the M-stage.
package mips_pkg;

  localparam logic [1:0] SZ_WORD = 2'b11;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [31:0] DM_BASE = 32'h0000_0000;

  localparam logic [4:0] AdEL = 5'd4;
  localparam logic [4:0] AdES = 5'd5;

  // Lane enables follow the low address bits even when alignment is not checked.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_WORD: return 4'b1111;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: return 4'b0001 << a;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_WORD: return a != 2'b00;
      SZ_HALF: return a[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_stage_if.sv
// M-stage data-memory bus: M-stage request, M/W boundary results and the
// combinational peripheral-bridge / address-error outputs.
interface dm_stage_if;
  logic        flush_M;
  logic        MemWrite_M;
  logic        MemRead_M;
  logic [1:0]  sizesel_M;
  logic        signedsel_M;
  logic [31:0] ALUout_M;
  logic [31:0] WD_M;

  logic [31:0] DM_Wtemp;
  logic        HitDMW;
  logic [31:0] ALUout_W;
  logic [1:0]  loadselW;
  logic        signedselW;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWe;
  logic        AdEL_M;
  logic        AdES_M;

  modport master (
    output flush_M, MemWrite_M, MemRead_M, sizesel_M, signedsel_M, ALUout_M, WD_M,
    input  DM_Wtemp, HitDMW, ALUout_W, loadselW, signedselW,
    input  PrAddr, PrWD, PrWe, AdEL_M, AdES_M
  );

  modport slave (
    input  flush_M, MemWrite_M, MemRead_M, sizesel_M, signedsel_M, ALUout_M, WD_M,
    output DM_Wtemp, HitDMW, ALUout_W, loadselW, signedselW,
    output PrAddr, PrWD, PrWe, AdEL_M, AdES_M
  );
endinterface

// File: rtl/dm_ram.sv
// Word-organised data memory with per-byte write enables and a registered,
// read-enabled output that returns zero on cycles without a read.
module dm_ram #(
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= 32'h0;
    else        rdata_q <= re_i ? mem[addr_i] : 32'h0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_stage.sv
// M-stage data-memory access: hit decode, byte lanes, bridge outputs and the
// M/W boundary register. Define DM_ALIGN_CHECK_EN to enable misalign detection.
module dm_stage
  import mips_pkg::*;
#(
  parameter int          DM_WORDS = 4096,
  parameter logic [31:0] DM_BASE  = mips_pkg::DM_BASE
) (
  input logic       clk,
  input logic       reset,
  dm_stage_if.slave bus
);

  localparam int          AW       = $clog2(DM_WORDS);
  localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) * 33'd4;

  logic [32:0] off;
  logic        hit;
  logic        size_ok;
  logic        misalign;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic        dm_we;
  logic        dm_re;
  logic        bubble;

  logic [31:0] alu_w_q, alu_w_d;
  logic [1:0]  ls_w_q, ls_w_d;
  logic        ss_w_q, ss_w_d;
  logic        hit_w_q, hit_w_d;

  // 33-bit offset so addresses below DM_BASE wrap to a huge value and miss.
  assign off     = {1'b0, bus.ALUout_M} - {1'b0, DM_BASE};
  assign hit     = off < DM_BYTES;
  assign size_ok = bus.sizesel_M != 2'b00;
  assign be      = byte_en(bus.sizesel_M, bus.ALUout_M[1:0]);

`ifdef DM_ALIGN_CHECK_EN
  assign misalign = (bus.MemRead_M | bus.MemWrite_M) & misaligned(bus.sizesel_M, bus.ALUout_M[1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    wlanes = bus.WD_M;
    case (bus.sizesel_M)
      SZ_HALF: wlanes = {2{bus.WD_M[15:0]}};
      SZ_BYTE: wlanes = {4{bus.WD_M[7:0]}};
      default: wlanes = bus.WD_M;
    endcase
  end

  // Write is gated by reset so a store in flight is dropped when reset falls.
  assign dm_we = bus.MemWrite_M & hit & size_ok & ~misalign & ~bus.flush_M & reset;
  assign dm_re = bus.MemRead_M & ~bus.MemWrite_M & hit & size_ok & ~misalign & ~bus.flush_M;

  dm_ram #(.DEPTH(DM_WORDS)) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .addr_i  (off[AW+1:2]),
    .we_i    (dm_we ? be : 4'b0000),
    .wdata_i (wlanes),
    .re_i    (dm_re),
    .rdata_o (bus.DM_Wtemp)
  );

  assign bus.PrAddr = bus.ALUout_M;
  assign bus.PrWD   = bus.WD_M;
  assign bus.PrWe   = bus.MemWrite_M & ~hit & size_ok & ~misalign & ~bus.flush_M;
  assign bus.AdEL_M = bus.MemRead_M & misalign & ~bus.flush_M;
  assign bus.AdES_M = bus.MemWrite_M & misalign & ~bus.flush_M;

  assign bubble = bus.flush_M | misalign;

  always_comb begin
    alu_w_d = bus.ALUout_M;
    ls_w_d  = bus.sizesel_M;
    ss_w_d  = bus.signedsel_M;
    hit_w_d = hit & bus.MemRead_M & ~bus.MemWrite_M & size_ok;
    if (bubble) begin
      alu_w_d = 32'h0;
      ls_w_d  = 2'b00;
      ss_w_d  = 1'b0;
      hit_w_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_w_q <= 32'h0;
      ls_w_q  <= 2'b00;
      ss_w_q  <= 1'b0;
      hit_w_q <= 1'b0;
    end else begin
      alu_w_q <= alu_w_d;
      ls_w_q  <= ls_w_d;
      ss_w_q  <= ss_w_d;
      hit_w_q <= hit_w_d;
    end
  end

  assign bus.ALUout_W   = alu_w_q;
  assign bus.loadselW   = ls_w_q;
  assign bus.signedselW = ss_w_q;
  assign bus.HitDMW     = hit_w_q;

endmodule

// File: tb/tb_dm_stage.sv
// Scoreboard bench for dm_stage: directed M-stage vectors push expected W
// results; a negedge monitor pops and compares them one cycle later.
module tb_dm_stage;
  import mips_pkg::*;

`ifdef DM_ALIGN_CHECK_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_stage_if bus();

  dm_stage #(.DM_WORDS(4096), .DM_BASE(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int          due;
    string       name;
    logic [31:0] dm;
    logic        hit;
    logic [31:0] alu;
    logic [1:0]  ls;
    logic        ss;
  } wexp_t;

  wexp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wexp_t e;
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk({e.name, ".DM_Wtemp"},   bus.DM_Wtemp, e.dm);
      chk({e.name, ".HitDMW"},     32'(bus.HitDMW), 32'(e.hit));
      chk({e.name, ".ALUout_W"},   bus.ALUout_W, e.alu);
      chk({e.name, ".loadselW"},   32'(bus.loadselW), 32'(e.ls));
      chk({e.name, ".signedselW"}, 32'(bus.signedselW), 32'(e.ss));
      $display("W %-10s dm=%h hit=%b alu=%h ls=%b ss=%b", e.name, bus.DM_Wtemp,
               bus.HitDMW, bus.ALUout_W, bus.loadselW, bus.signedselW);
    end
  end

  task automatic drive(input logic we, input logic re, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic fl);
    bus.MemWrite_M  = we;
    bus.MemRead_M   = re;
    bus.sizesel_M   = sz;
    bus.signedsel_M = sg;
    bus.ALUout_M    = a;
    bus.WD_M        = wd;
    bus.flush_M     = fl;
  endtask

  task automatic issue(input string nm, input logic we, input logic re, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd, input logic fl,
                       input logic pw, input logic el, input logic es,
                       input logic [31:0] edm, input logic ehit, input logic [31:0] ealu,
                       input logic [1:0] els, input logic ess);
    wexp_t e;
    @(posedge clk);
    #1;
    drive(we, re, sz, sg, a, wd, fl);
    e.due = cyc + 1; e.name = nm; e.dm = edm; e.hit = ehit; e.alu = ealu; e.ls = els; e.ss = ess;
    q.push_back(e);
    #1;
    chk({nm, ".PrWe"},   32'(bus.PrWe), 32'(pw));
    chk({nm, ".AdEL_M"}, 32'(bus.AdEL_M), 32'(el));
    chk({nm, ".AdES_M"}, 32'(bus.AdES_M), 32'(es));
    chk({nm, ".PrAddr"}, bus.PrAddr, a);
    chk({nm, ".PrWD"},   bus.PrWD, wd);
  endtask

  logic [31:0] w0, w1;

  initial begin
    wexp_t e;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    chk("rst.DM_Wtemp",   bus.DM_Wtemp, 32'h0);
    chk("rst.HitDMW",     32'(bus.HitDMW), 32'h0);
    chk("rst.ALUout_W",   bus.ALUout_W, 32'h0);
    chk("rst.loadselW",   32'(bus.loadselW), 32'h0);
    chk("rst.signedselW", 32'(bus.signedselW), 32'h0);
    chk("rst.PrWe",       32'(bus.PrWe), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    w0 = 32'hBEEFAA78;
    w1 = AC ? w0 : 32'h55667788;

    //    name        we    re    sz       sg    addr          wdata         fl    pw    el    es    dm             hit   alu           ls       ss
    issue("sw10",     1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10,       32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h10,       SZ_WORD, 1'b0);
    issue("lw10a",    1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678,  1'b1, 32'h10,       SZ_WORD, 1'b0);
    issue("sh12",     1'b1, 1'b0, SZ_HALF, 1'b0, 32'h12,       32'h0000BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h12,       SZ_HALF, 1'b0);
    issue("sb11",     1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h11,       32'h000000AA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h11,       SZ_BYTE, 1'b0);
    issue("lw10b",    1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, w0,            1'b1, 32'h10,       SZ_WORD, 1'b0);
    issue("sw13",     1'b1, 1'b0, SZ_WORD, 1'b0, 32'h13,       32'h55667788, 1'b0, 1'b0, 1'b0, AC,   32'h0,         1'b0, AC ? 32'h0 : 32'h13, AC ? 2'b00 : SZ_WORD, 1'b0);
    issue("lw10c",    1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, w1,            1'b1, 32'h10,       SZ_WORD, 1'b0);
    issue("sw7f10",   1'b1, 1'b0, SZ_WORD, 1'b0, 32'h7F10,     32'hCAFE0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h7F10,     SZ_WORD, 1'b0);
    issue("lw7f10",   1'b0, 1'b1, SZ_WORD, 1'b0, 32'h7F10,     32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h7F10,     SZ_WORD, 1'b0);
    issue("swflush",  1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10,       32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        2'b00,   1'b0);
    issue("lw10d",    1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, w1,            1'b1, 32'h10,       SZ_WORD, 1'b0);
    issue("lh12s",    1'b0, 1'b1, SZ_HALF, 1'b1, 32'h12,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, w1,            1'b1, 32'h12,       SZ_HALF, 1'b1);
    issue("lw12",     1'b0, 1'b1, SZ_WORD, 1'b0, 32'h12,       32'h0,        1'b0, 1'b0, AC,   1'b0, AC ? 32'h0 : w1, ~AC, AC ? 32'h0 : 32'h12, AC ? 2'b00 : SZ_WORD, 1'b0);

    // Store in flight when reset falls: nothing committed, W cleared at once.
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h01020304, 1'b0);
    e.due = cyc + 1; e.name = "swrst"; e.dm = 32'h0; e.hit = 1'b0; e.alu = 32'h0; e.ls = 2'b00; e.ss = 1'b0;
    q.push_back(e);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst.DM_Wtemp",   bus.DM_Wtemp, 32'h0);
    chk("arst.HitDMW",     32'(bus.HitDMW), 32'h0);
    chk("arst.ALUout_W",   bus.ALUout_W, 32'h0);
    chk("arst.loadselW",   32'(bus.loadselW), 32'h0);
    chk("arst.signedselW", 32'(bus.signedselW), 32'h0);
    @(negedge clk);
    #2;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;

    issue("lw10e",    1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, w1,            1'b1, 32'h10,       SZ_WORD, 1'b0);

    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
